// File: rtl/axi_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_mem_slave
// Description : Parametrised AXI4 slave memory with FIXED/INCR/WRAP bursts,
//               byte strobes and SLVERR signalling. The write path (AW/W/B)
//               and read path (AR/R) are independent state machines sharing
//               one word-addressed array.
// Ports       :
//   aclk, areset_n               clock, synchronous active-low reset
//   awaddr/awlen/awburst         write burst request (awvalid/awready)
//   wdata/wstrb/wlast            write data beat (wvalid/wready)
//   bresp                        write response (bvalid/bready)
//   araddr/arlen/arburst         read burst request (arvalid/arready)
//   rdata/rresp/rlast            read data beat (rvalid/rready)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module axi_burst_mem_slave #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int MAX_LEN = 16
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    // write address channel
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    // write data channel
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    // write response channel
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    // read address channel
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    // read data channel
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BYTES = DATA_W / 8;
    localparam int c_ALSB  = $clog2(c_BYTES);   // byte-offset bits in an address
    localparam int c_IDX_W = $clog2(DEPTH);     // word index width (DEPTH >= 2)

    // Clears the byte-offset bits so all address arithmetic is word-aligned.
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~(ADDR_W'(c_BYTES - 1));

    localparam logic [1:0] c_BURST_FIXED    = 2'b00;
    localparam logic [1:0] c_BURST_INCR     = 2'b01;
    localparam logic [1:0] c_BURST_WRAP     = 2'b10;
    localparam logic [1:0] c_BURST_RESERVED = 2'b11;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    // ------------------------------------------------------------------------
    // Address helpers
    // ------------------------------------------------------------------------
    // Address of the beat following 'addr'. For WRAP the window is
    // (len+1)*c_BYTES bytes, aligned to its own size; only the bits inside the
    // window advance, the bits above it stay fixed. WRAP lengths reaching this
    // function with a non power-of-two span belong to an erroneous burst whose
    // addresses are never used for memory access.
    function automatic logic [ADDR_W-1:0] f_next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] span;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] inc;
        span = (ADDR_W'(len) + ADDR_W'(1)) << c_ALSB;
        mask = span - ADDR_W'(1);
        inc  = addr + ADDR_W'(c_BYTES);
        case (burst)
            c_BURST_FIXED: f_next_addr = addr;
            c_BURST_INCR:  f_next_addr = inc;
            c_BURST_WRAP:  f_next_addr = (addr & ~mask) | (inc & mask);
            default:       f_next_addr = inc;
        endcase
    endfunction

    // Whole-burst errors: reserved burst type, too many beats, or a WRAP
    // length that is not 2/4/8/16 beats.
    function automatic logic f_burst_bad(
        input logic [7:0] len,
        input logic [1:0] burst
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        f_burst_bad = (burst == c_BURST_RESERVED)
                   || ((int'(len) + 1) > MAX_LEN)
                   || ((burst == c_BURST_WRAP) && !wrap_len_ok);
    endfunction

    // A word index is in range when no address bit above the index is set.
    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        f_in_range = ((addr >> (c_ALSB + c_IDX_W)) == '0);
    endfunction

    function automatic logic [c_IDX_W-1:0] f_word_idx(input logic [ADDR_W-1:0] addr);
        f_word_idx = addr[c_ALSB +: c_IDX_W];
    endfunction

    // ------------------------------------------------------------------------
    // Storage (never reset: contents survive areset_n)
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------------
    logic [1:0]        r_wstate;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen;
    logic [1:0]        r_wburst;
    logic [7:0]        r_wcnt;
    logic              r_wbad;      // whole burst is erroneous: suppress writes
    logic              r_werr;      // sticky: some beat (or the burst) erred
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_w_final;
    logic              w_w_in_range;
    logic              w_w_beat_err;
    logic              w_mem_we;
    logic [c_IDX_W-1:0] w_widx;

    assign w_aw_hs      = r_awready & awvalid;
    assign w_w_hs       = r_wready & wvalid;
    assign w_w_final    = (r_wcnt == r_wlen);
    assign w_w_in_range = f_in_range(r_waddr);
    assign w_widx       = f_word_idx(r_waddr);
    // A beat errs when it falls off the end of memory or when wlast disagrees
    // with the beat count; the count alone decides where the burst ends.
    assign w_w_beat_err = !w_w_in_range || (wlast != w_w_final);
    // The write is gated by reset so a burst abandoned by reset leaves no
    // trace in the reset cycle itself.
    assign w_mem_we     = areset_n & w_w_hs & !r_wbad & w_w_in_range;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_wstate  <= c_W_IDLE;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wburst  <= '0;
            r_wcnt    <= '0;
            r_wbad    <= 1'b0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    // awready rises on the first cycle out of reset.
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_waddr   <= awaddr & c_ALIGN_MASK;
                        r_wlen    <= awlen;
                        r_wburst  <= awburst;
                        r_wcnt    <= '0;
                        r_wbad    <= f_burst_bad(awlen, awburst);
                        r_werr    <= f_burst_bad(awlen, awburst);
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= c_W_DATA;
                    end
                end
                c_W_DATA: begin
                    if (w_w_hs) begin
                        if (w_w_beat_err) begin
                            r_werr <= 1'b1;
                        end
                        if (w_w_final) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_w_beat_err) ? c_RESP_SLVERR : c_RESP_OKAY;
                            r_wstate <= c_W_RESP;
                        end else begin
                            r_wcnt  <= r_wcnt + 8'd1;
                            r_waddr <= f_next_addr(r_waddr, r_wlen, r_wburst);
                        end
                    end
                end
                c_W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= c_RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wstate  <= c_W_IDLE;
                    end
                end
                default: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_wstate  <= c_W_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write. Lanes with wstrb low keep their previous contents.
    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    logic [0:0]        r_rstate;
    logic [ADDR_W-1:0] r_raddr;     // address of the beat currently presented
    logic [7:0]        r_rlen;
    logic [1:0]        r_rburst;
    logic [7:0]        r_rcnt;      // index of the beat currently presented
    logic              r_rbad;
    logic              r_arready;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;

    logic              w_ar_hs;
    logic              w_r_hs;
    logic [ADDR_W-1:0] w_rsel_addr;
    logic              w_rsel_bad;
    logic              w_rsel_ok;
    logic [DATA_W-1:0] w_rsel_data;

    assign w_ar_hs = r_arready & arvalid;
    assign w_r_hs  = r_rvalid & rready;

    // Beat to load into the output registers at the next edge: beat 0 of the
    // incoming request while idle, otherwise the successor of the current
    // beat. The array is sampled before any same-edge write lands, so a
    // simultaneous write to the same word is seen as old data.
    assign w_rsel_addr = (r_rstate == c_R_IDLE) ? (araddr & c_ALIGN_MASK)
                                                : f_next_addr(r_raddr, r_rlen, r_rburst);
    assign w_rsel_bad  = (r_rstate == c_R_IDLE) ? f_burst_bad(arlen, arburst) : r_rbad;
    assign w_rsel_ok   = !w_rsel_bad && f_in_range(w_rsel_addr);
    assign w_rsel_data = w_rsel_ok ? r_mem[f_word_idx(w_rsel_addr)] : '0;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_rstate  <= c_R_IDLE;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rburst  <= '0;
            r_rcnt    <= '0;
            r_rbad    <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_RESP_OKAY;
            r_rlast   <= 1'b0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_raddr   <= w_rsel_addr;
                        r_rlen    <= arlen;
                        r_rburst  <= arburst;
                        r_rbad    <= w_rsel_bad;
                        r_rcnt    <= '0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rsel_data;
                        r_rresp   <= w_rsel_ok ? c_RESP_OKAY : c_RESP_SLVERR;
                        r_rlast   <= (arlen == 8'd0);
                        r_arready <= 1'b0;
                        r_rstate  <= c_R_DATA;
                    end
                end
                c_R_DATA: begin
                    // Output registers only move on acceptance, which holds
                    // rdata/rresp/rlast stable through back-pressure.
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rdata   <= '0;
                            r_rresp   <= c_RESP_OKAY;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= c_R_IDLE;
                        end else begin
                            r_raddr <= w_rsel_addr;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rdata <= w_rsel_data;
                            r_rresp <= w_rsel_ok ? c_RESP_OKAY : c_RESP_SLVERR;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        end
                    end
                end
                default: begin
                    r_rvalid <= 1'b0;
                    r_rstate <= c_R_IDLE;
                end
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_mem_slave
// Description : Directed self-checking bench for axi_burst_mem_slave
//               (ADDR_W=32, DATA_W=32, DEPTH=256, MAX_LEN=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_mem_slave;

    logic        aclk;
    logic        areset_n;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wd      [0:31];
    logic [31:0] ed      [0:31];
    logic [1:0]  er      [0:31];
    logic [31:0] rd_data [0:31];
    logic [1:0]  rd_resp [0:31];
    logic        rd_last [0:31];
    int          nr;

    logic [1:0]  resp;
    int          nbeats;
    int          cnt;

    axi_burst_mem_slave #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (256),
        .MAX_LEN(16)
    ) dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arlen   (arlen),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One write burst using wd[]; 'early' forces wlast on that beat index.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb,
                            input int early, output logic [1:0] bres, output int beats);
        int c;
        awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        c = 0;
        do begin @(negedge aclk); c++; end while (!awready && c < 100);
        check("aw_ready", {63'd0, awready}, 64'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        beats = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = strb;
            wlast = (i == int'(len)) || (i == early);
            wvalid = 1'b1;
            c = 0;
            do begin @(negedge aclk); c++; end while (!wready && c < 100);
            if (wready) beats++;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        c = 0;
        do begin @(negedge aclk); c++; end while (!bvalid && c < 100);
        check("b_valid", {63'd0, bvalid}, 64'd1);
        bres = bresp;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // One read burst into rd_*; optional random rready back-pressure.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input bit stall);
        int c;
        int cyc;
        bit held_ok;
        logic [34:0] held;
        araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        c = 0;
        do begin @(negedge aclk); c++; end while (!arready && c < 100);
        check("ar_ready", {63'd0, arready}, 64'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        rready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        nr = 0; cyc = 0; held_ok = 1'b0; held = '0;
        while (nr <= int'(len) && cyc < 300) begin
            @(negedge aclk);
            if (cyc == 0) check("r_first_latency", {63'd0, rvalid}, 64'd1);
            if (rvalid) begin
                if (held_ok) begin
                    check("r_stable", {29'd0, rresp, rlast, rdata}, {29'd0, held});
                    held_ok = 1'b0;
                end
                if (rready) begin
                    rd_data[nr] = rdata; rd_resp[nr] = rresp; rd_last[nr] = rlast;
                    nr++;
                end else begin
                    held = {rresp, rlast, rdata};
                    held_ok = 1'b1;
                end
            end
            @(posedge aclk); #1;
            if (nr <= int'(len)) rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            else                 rready = 1'b0;
            cyc++;
        end
        rready = 1'b0;
        check("r_beat_count", 64'(nr), 64'(int'(len) + 1));
        check("r_idle_after", {63'd0, rvalid}, 64'd0);
    endtask

    // Compare the captured beats against ed[]/er[]; rlast only on the last.
    task automatic check_beats(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), {32'd0, rd_data[i]}, {32'd0, ed[i]});
            check($sformatf("%s_resp%0d", tag, i), {62'd0, rd_resp[i]}, {62'd0, er[i]});
            check($sformatf("%s_last%0d", tag, i), {63'd0, rd_last[i]}, {63'd0, (i == n - 1)});
        end
    endtask

    initial begin
        areset_n = 1'b0;
        awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", {63'd0, awready}, 64'd0);
        check("rst_wready",  {63'd0, wready},  64'd0);
        check("rst_bvalid",  {63'd0, bvalid},  64'd0);
        check("rst_arready", {63'd0, arready}, 64'd0);
        check("rst_rvalid",  {63'd0, rvalid},  64'd0);
        check("rst_rlast",   {63'd0, rlast},   64'd0);
        areset_n = 1'b1;
        @(posedge aclk); #1;
        check("rel_awready", {63'd0, awready}, 64'd1);
        check("rel_arready", {63'd0, arready}, 64'd1);

        // ---- INCR write 0x4 len 3, read back ----
        for (int i = 0; i < 4; i++) wd[i] = 32'hdeadbeef + 32'(i);
        do_write(32'h4, 8'd3, 2'b01, 4'hf, -1, resp, nbeats);
        check("incr_w_bresp", {62'd0, resp}, 64'd0);
        check("incr_w_beats", 64'(nbeats), 64'd4);
        do_read(32'h4, 8'd3, 2'b01, 1'b0);
        ed[0] = 32'hdeadbeef; ed[1] = 32'hdeadbef0; ed[2] = 32'hdeadbef1; ed[3] = 32'hdeadbef2;
        for (int i = 0; i < 4; i++) er[i] = 2'b00;
        check_beats("incr_r", 4);

        // ---- WRAP read 0x18 len 3: word order 6,7,4,5 ----
        for (int i = 0; i < 4; i++) wd[i] = 32'ha0000004 + 32'(i);
        do_write(32'h10, 8'd3, 2'b01, 4'hf, -1, resp, nbeats);
        check("fill_w_bresp", {62'd0, resp}, 64'd0);
        do_read(32'h18, 8'd3, 2'b10, 1'b0);
        ed[0] = 32'ha0000006; ed[1] = 32'ha0000007; ed[2] = 32'ha0000004; ed[3] = 32'ha0000005;
        check_beats("wrap_r", 4);

        // ---- FIXED write 4 beats to 0x8: word 2 keeps last beat, word 3 untouched ----
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        do_write(32'h8, 8'd3, 2'b00, 4'hf, -1, resp, nbeats);
        check("fixed_w_bresp", {62'd0, resp}, 64'd0);
        do_read(32'h8, 8'd1, 2'b01, 1'b0);
        ed[0] = 32'h44; ed[1] = 32'hdeadbef1;
        check_beats("fixed_r", 2);

        // ---- byte strobes: 0x11223344 with 0101 over 0xffffffff ----
        wd[0] = 32'hffffffff;
        do_write(32'h28, 8'd0, 2'b01, 4'hf, -1, resp, nbeats);
        wd[0] = 32'h11223344;
        do_write(32'h28, 8'd0, 2'b01, 4'b0101, -1, resp, nbeats);
        check("strb_w_bresp", {62'd0, resp}, 64'd0);
        do_read(32'h28, 8'd0, 2'b01, 1'b0);
        ed[0] = 32'hff22ff44;
        check_beats("strb_r", 1);

        // ---- INCR write from word 254 across the top of memory ----
        for (int i = 0; i < 4; i++) wd[i] = 32'hc0 + 32'(i);
        do_write(32'h3f8, 8'd3, 2'b01, 4'hf, -1, resp, nbeats);
        check("range_w_bresp", {62'd0, resp}, 64'd2);
        check("range_w_beats", 64'(nbeats), 64'd4);
        do_read(32'h3f8, 8'd3, 2'b01, 1'b0);
        ed[0] = 32'hc0; ed[1] = 32'hc1; ed[2] = 32'h0; ed[3] = 32'h0;
        er[0] = 2'b00;  er[1] = 2'b00;  er[2] = 2'b10; er[3] = 2'b10;
        check_beats("range_r", 4);

        // ---- reserved awburst: all beats taken, no write, SLVERR ----
        for (int i = 0; i < 4; i++) wd[i] = 32'h0;
        do_write(32'h28, 8'd3, 2'b11, 4'hf, -1, resp, nbeats);
        check("rsvd_w_bresp", {62'd0, resp}, 64'd2);
        check("rsvd_w_beats", 64'(nbeats), 64'd4);
        do_read(32'h28, 8'd0, 2'b01, 1'b0);
        ed[0] = 32'hff22ff44; er[0] = 2'b00;
        check_beats("rsvd_w_mem", 1);

        // ---- reserved arburst and illegal WRAP length on the read side ----
        do_read(32'h10, 8'd1, 2'b11, 1'b0);
        ed[0] = 32'h0; ed[1] = 32'h0; er[0] = 2'b10; er[1] = 2'b10;
        check_beats("rsvd_r", 2);
        do_read(32'h10, 8'd2, 2'b10, 1'b0);
        ed[2] = 32'h0; er[2] = 2'b10;
        check_beats("wrap3_r", 3);

        // ---- burst longer than MAX_LEN: no write ----
        wd[0] = 32'h12345678;
        do_write(32'h80, 8'd0, 2'b01, 4'hf, -1, resp, nbeats);
        for (int i = 0; i < 17; i++) wd[i] = 32'h0;
        do_write(32'h80, 8'd16, 2'b01, 4'hf, -1, resp, nbeats);
        check("long_w_bresp", {62'd0, resp}, 64'd2);
        check("long_w_beats", 64'(nbeats), 64'd17);
        do_read(32'h80, 8'd0, 2'b01, 1'b0);
        ed[0] = 32'h12345678; er[0] = 2'b00;
        check_beats("long_w_mem", 1);

        // ---- early wlast on beat 1 of a 4-beat burst ----
        for (int i = 0; i < 4; i++) wd[i] = 32'h5a5a0000 + 32'(i);
        do_write(32'h40, 8'd3, 2'b01, 4'hf, 1, resp, nbeats);
        check("wlast_w_bresp", {62'd0, resp}, 64'd2);
        check("wlast_w_beats", 64'(nbeats), 64'd4);

        // ---- random rready stalls ----
        do_read(32'h10, 8'd3, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ed[i] = 32'ha0000004 + 32'(i);
            er[i] = 2'b00;
        end
        check_beats("stall_r", 4);

        // ---- reset in the middle of a read burst ----
        araddr = 32'h10; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        cnt = 0;
        do begin @(negedge aclk); cnt++; end while (!arready && cnt < 100);
        check("mid_ar_ready", {63'd0, arready}, 64'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(posedge aclk); #1;
        areset_n = 1'b0;
        @(posedge aclk); #1;
        check("mid_rst_rvalid",  {63'd0, rvalid},  64'd0);
        check("mid_rst_arready", {63'd0, arready}, 64'd0);
        areset_n = 1'b1; rready = 1'b0;
        @(posedge aclk); #1;
        check("mid_rel_arready", {63'd0, arready}, 64'd1);
        check("mid_rel_rvalid",  {63'd0, rvalid},  64'd0);
        do_read(32'h10, 8'd0, 2'b01, 1'b0);
        ed[0] = 32'ha0000004; er[0] = 2'b00;
        check_beats("mem_kept", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
